// File: rtl/spi_ram_ctrl_if.sv
// rtl/spi_ram_ctrl_if.sv - command/response and RAM bus bundle for spi_ram_ctrl
//
// Purpose: groups every non-clock signal of spi_ram_ctrl into one bundle.
// Ports (as seen from the controller, modport master):
//   rx_data[9:0]   in   command word: [9:8] command, [7:0] address or data
//   rx_valid       in   one-cycle strobe qualifying rx_data
//   tx_data[7:0]   out  read data returned to the SPI slave
//   tx_valid       out  one-cycle strobe qualifying tx_data
//   ram_en         out  RAM access enable
//   ram_we         out  RAM write enable (meaningful only with ram_en)
//   ram_addr[7:0]  out  RAM address
//   ram_wdata[7:0] out  RAM write data
//   ram_rdata[7:0] in   RAM read data, valid the cycle after a read access
//   busy           out  controller is not idle
//   err[1:0]       out  sticky flags: [0] overrun, [1] illegal request
// The slave modport is the environment side (SPI slave plus RAM).
interface spi_ram_ctrl_if;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       ram_en;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic       busy;
   logic [1:0] err;

   modport master (
      input  rx_data, rx_valid, ram_rdata,
      output tx_data, tx_valid, ram_en, ram_we, ram_addr, ram_wdata, busy, err
   );

   modport slave (
      output rx_data, rx_valid, ram_rdata,
      input  tx_data, tx_valid, ram_en, ram_we, ram_addr, ram_wdata, busy, err
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI command word to single-port RAM access controller
//
// Purpose: decodes 10-bit command words from an SPI slave into RAM writes and
// reads. cmd 00 sets the write address, cmd 01 writes a byte, cmd 10 sets the
// read address, cmd 11 reads a byte back onto tx_data/tx_valid.
// Ports:
//   SCK    in  single clock, all state changes on its rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    spi_ram_ctrl_if.master (rx/tx command stream, RAM bus, busy, err)
// Parameter: MEM_DEPTH (2..256) RAM words; addresses at or above it are illegal
// and auto-incremented addresses wrap from MEM_DEPTH-1 to 0.
// Optional feature macro: SPI_RAM_ADDR_AUTOINC_EN - when defined, wr_addr steps
// after each write and rd_addr after each completed read.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256
) (
   input logic             SCK,
   input logic             rst_n,
   spi_ram_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      RD_ISSUE = 2'd2,
      RD_WAIT  = 2'd3
   } state_t;

   localparam logic [8:0] DEPTH9 = 9'(MEM_DEPTH);

`ifdef SPI_RAM_ADDR_AUTOINC_EN
   localparam logic [7:0] LAST_ADDR = 8'(MEM_DEPTH - 1);

   function automatic logic [7:0] next_addr(input logic [7:0] a);
      return (a == LAST_ADDR) ? 8'd0 : a + 8'd1;
   endfunction
`endif

   state_t     state_q, state_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] rd_addr_q, rd_addr_d;
   logic       rd_addr_vld_q, rd_addr_vld_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic       ram_en_q, ram_en_d;
   logic       ram_we_q, ram_we_d;
   logic [7:0] ram_addr_q, ram_addr_d;
   logic [7:0] ram_wdata_q, ram_wdata_d;
   logic       busy_q, busy_d;
   logic [1:0] err_q, err_d;

   logic       addr_in_range;

   // Address field of cmd 00/10 must name an existing RAM word.
   assign addr_in_range = ({1'b0, bus.rx_data[7:0]} < DEPTH9);

   always_ff @(posedge SCK or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wr_addr_q     <= 8'd0;
         rd_addr_q     <= 8'd0;
         rd_addr_vld_q <= 1'b0;
         tx_data_q     <= 8'd0;
         tx_valid_q    <= 1'b0;
         ram_en_q      <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= 8'd0;
         ram_wdata_q   <= 8'd0;
         busy_q        <= 1'b0;
         err_q         <= 2'b00;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         rd_addr_vld_q <= rd_addr_vld_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         ram_en_q      <= ram_en_d;
         ram_we_q      <= ram_we_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
      end
   end

   // Next-state logic. Outputs are computed alongside the state so that they
   // are registered together: ram_en is high exactly while the state register
   // holds WRITE or RD_ISSUE, and tx_valid is high the cycle after RD_WAIT.
   always_comb begin
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      rd_addr_d     = rd_addr_q;
      rd_addr_vld_d = rd_addr_vld_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = 1'b0;
      ram_en_d      = 1'b0;
      ram_we_d      = 1'b0;
      ram_addr_d    = ram_addr_q;
      ram_wdata_d   = ram_wdata_q;
      err_d         = err_q;

      case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               case (bus.rx_data[9:8])
                  2'b00: begin
                     if (addr_in_range) wr_addr_d = bus.rx_data[7:0];
                     else               err_d[1]  = 1'b1;
                  end
                  2'b01: begin
                     state_d     = WRITE;
                     ram_en_d    = 1'b1;
                     ram_we_d    = 1'b1;
                     ram_addr_d  = wr_addr_q;
                     ram_wdata_d = bus.rx_data[7:0];
`ifdef SPI_RAM_ADDR_AUTOINC_EN
                     wr_addr_d   = next_addr(wr_addr_q);
`endif
                  end
                  2'b10: begin
                     if (addr_in_range) begin
                        rd_addr_d     = bus.rx_data[7:0];
                        rd_addr_vld_d = 1'b1;
                     end else begin
                        err_d[1] = 1'b1;
                     end
                  end
                  2'b11: begin
                     if (rd_addr_vld_q) begin
                        state_d    = RD_ISSUE;
                        ram_en_d   = 1'b1;
                        ram_addr_d = rd_addr_q;
                     end else begin
                        err_d[1] = 1'b1;
                     end
                  end
               endcase
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         RD_ISSUE: begin
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            // RAM data for the RD_ISSUE access is valid during this cycle.
            state_d    = IDLE;
            tx_data_d  = bus.ram_rdata;
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            rd_addr_d  = next_addr(rd_addr_q);
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A strobe arriving while a command is in flight is dropped.
      if (bus.rx_valid && (state_q != IDLE)) err_d[0] = 1'b1;

      busy_d = (state_d != IDLE);
   end

   assign bus.tx_data   = tx_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.ram_en    = ram_en_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - self-checking bench for spi_ram_ctrl
module tb_spi_ram_ctrl;

   localparam int DEPTH = 200;

   logic SCK;
   logic rst_n;
   spi_ram_ctrl_if bus();

   spi_ram_ctrl #(.MEM_DEPTH(DEPTH)) dut (
      .SCK   (SCK),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial SCK = 1'b0;
   always #5 SCK = ~SCK;

   // RAM model: preset contents i ^ 0x5A, read data valid the cycle after access.
   bit         loaded = 1'b0;
   logic [7:0] mem [256];

   always @(posedge SCK) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
         loaded <= 1'b1;
      end else if (bus.ram_en && bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
      end else if (bus.ram_en) begin
         bus.ram_rdata <= mem[bus.ram_addr];
      end
   end

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         cyc;
   } ram_exp_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } tx_exp_t;

   typedef struct {
      logic [9:0] word;
      bit         ram;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      bit         tx;
      logic [7:0] txd;
      logic [1:0] err;
   } vec_t;

   ram_exp_t   exp_ram[$];
   tx_exp_t    exp_tx[$];
   vec_t       vec[16];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] last_tx;

`ifdef SPI_RAM_ADDR_AUTOINC_EN
   localparam logic [7:0] E_A2 = 8'h00, E_D1 = 8'h11, E_A3 = 8'h00;
`else
   localparam logic [7:0] E_A2 = 8'hC7, E_D1 = 8'h22, E_A3 = 8'hC7;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: wait for the falling edge, then score any RAM access or tx strobe.
   task automatic tick();
      ram_exp_t r;
      tx_exp_t  t;
      @(negedge SCK);
      cyc++;
      if (rst_n) begin
         if (bus.ram_en) begin
            chk("ram_en_expected", 32'(exp_ram.size() > 0), 32'd1);
            if (exp_ram.size() > 0) begin
               r = exp_ram.pop_front();
               chk("ram_we", 32'(bus.ram_we), 32'(r.we));
               chk("ram_addr", 32'(bus.ram_addr), 32'(r.addr));
               if (r.we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(r.wdata));
               chk("ram_cycle", cyc, r.cyc);
            end
         end else if (bus.ram_we) begin
            chk("ram_we_without_en", 32'(bus.ram_we), 32'd0);
         end
         if (bus.tx_valid) begin
            chk("tx_valid_expected", 32'(exp_tx.size() > 0), 32'd1);
            if (exp_tx.size() > 0) begin
               t = exp_tx.pop_front();
               chk("tx_data", 32'(bus.tx_data), 32'(t.data));
               chk("tx_cycle", cyc, t.cyc);
            end
         end
      end
   endtask

   task automatic send(input logic [9:0] w);
      bus.rx_data  = w;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic push_ram(input logic we, input logic [7:0] a, input logic [7:0] d);
      exp_ram.push_back('{we, a, d, cyc + 1});
   endtask

   task automatic push_tx(input logic [7:0] d);
      exp_tx.push_back('{d, cyc + 3});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      exp_ram.delete();
      exp_tx.delete();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain(input string tag);
      repeat (5) tick();
      chk({tag, "_ram_pending"}, 32'(exp_ram.size()), 32'd0);
      chk({tag, "_tx_pending"}, 32'(exp_tx.size()), 32'd0);
      exp_ram.delete();
      exp_tx.delete();
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.rx_data  = 10'd0;
      bus.rx_valid = 1'b0;

      vec[0]  = '{10'h005, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b00};
      vec[1]  = '{10'h1A5, 1, 1, 8'h05, 8'hA5, 0, 8'h00, 2'b00};
      vec[2]  = '{10'h266, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b00};
      vec[3]  = '{10'h300, 1, 0, 8'h66, 8'h00, 1, 8'h3C, 2'b00};
      vec[4]  = '{10'h205, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b00};
      vec[5]  = '{10'h300, 1, 0, 8'h05, 8'h00, 1, 8'hA5, 2'b00};
      vec[6]  = '{10'h0C7, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b00};
      vec[7]  = '{10'h1E1, 1, 1, 8'hC7, 8'hE1, 0, 8'h00, 2'b00};
      vec[8]  = '{10'h2C7, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b00};
      vec[9]  = '{10'h300, 1, 0, 8'hC7, 8'h00, 1, 8'hE1, 2'b00};
      vec[10] = '{10'h010, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b00};
      vec[11] = '{10'h0C8, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b10};
      vec[12] = '{10'h17E, 1, 1, 8'h10, 8'h7E, 0, 8'h00, 2'b10};
      vec[13] = '{10'h210, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b10};
      vec[14] = '{10'h2FF, 0, 0, 8'h00, 8'h00, 0, 8'h00, 2'b10};
      vec[15] = '{10'h300, 1, 0, 8'h10, 8'h00, 1, 8'h7E, 2'b10};

      // Reset values while rst_n is held low.
      repeat (3) tick();
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      tick();

      // Read with no read address since reset: illegal, no RAM access.
      send(10'h300);
      drain("rd_no_addr");
      chk("rd_no_addr_err", 32'(bus.err), 32'b10);
      chk("rd_no_addr_busy", 32'(bus.busy), 32'd0);

      // Table-driven command vectors from a fresh reset.
      do_reset();
      last_tx = 8'h00;
      for (int i = 0; i < 16; i++) begin
         if (vec[i].ram) push_ram(vec[i].we, vec[i].addr, vec[i].wdata);
         if (vec[i].tx) begin
            push_tx(vec[i].txd);
            last_tx = vec[i].txd;
         end
         send(vec[i].word);
         drain($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vec[i].err));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
         chk($sformatf("vec%0d_tx_hold", i), 32'(bus.tx_data), 32'(last_tx));
      end

      // Overrun: a write strobe one cycle after a read strobe is dropped.
      do_reset();
      send(10'h266);
      tick();
      push_ram(1'b0, 8'h66, 8'h00);
      push_tx(8'h3C);
      bus.rx_data  = 10'h300;
      bus.rx_valid = 1'b1;
      tick();
      chk("ovr_busy", 32'(bus.busy), 32'd1);
      bus.rx_data  = 10'h1FF;
      tick();
      bus.rx_valid = 1'b0;
      drain("ovr");
      chk("ovr_err", 32'(bus.err), 32'b01);

      // Reset asserted during RD_WAIT aborts the read.
      do_reset();
      send(10'h266);
      tick();
      push_ram(1'b0, 8'h66, 8'h00);
      push_tx(8'h3C);
      send(10'h300);
      repeat (4) tick();
      chk("abort_pre_tx_data", 32'(bus.tx_data), 32'h3C);
      push_ram(1'b0, 8'h66, 8'h00);
      send(10'h300);
      tick();
      rst_n = 1'b0;
      #1;
      chk("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("abort_tx_data", 32'(bus.tx_data), 32'd0);
      chk("abort_ram_en", 32'(bus.ram_en), 32'd0);
      chk("abort_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_err", 32'(bus.err), 32'd0);
      chk("abort_ram_consumed", 32'(exp_ram.size()), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      drain("abort_after");
      chk("abort_after_busy", 32'(bus.busy), 32'd0);
      send(10'h005);
      tick();
      push_ram(1'b1, 8'h05, 8'h5A);
      send(10'h15A);
      drain("abort_write");

      // Address auto-increment (or its absence) with wrap at DEPTH-1.
      do_reset();
      send(10'h0C7);
      tick();
      push_ram(1'b1, 8'hC7, 8'h11);
      send(10'h111);
      repeat (3) tick();
      push_ram(1'b1, E_A2, 8'h22);
      send(10'h122);
      repeat (3) tick();
      send(10'h2C7);
      tick();
      push_ram(1'b0, 8'hC7, 8'h00);
      push_tx(E_D1);
      send(10'h300);
      repeat (4) tick();
      push_ram(1'b0, E_A3, 8'h00);
      push_tx(8'h22);
      send(10'h300);
      drain("autoinc");
      chk("autoinc_err", 32'(bus.err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
